// File: rtl/fft_frame_feeder.sv
// Ping-pong framer: 8-bit samples into FRAME_LEN frames, streamed as AXI4-Stream to the FFT (Hann window when FFT_FEEDER_HANN_WINDOW_EN).
// Latency: tvalid rises 3 cycles after the edge capturing sample FRAME_LEN-1; 1 beat/cycle thereafter.
// Backpressure: tready stalls reads via occupancy credits over a 2-entry skid; a frame completing while the reader is busy is dropped.
module fft_frame_feeder #(
    parameter int FRAME_LEN = 512
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [7:0]  sample_in,
    input  logic        sample_valid_in,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        frame_drop_out,
    output logic [7:0]  drop_count_out
);
    localparam int AW = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM} state_t;

    state_t          state_q, state_d;
    logic            wbank_q, wbank_d, rbank_q, rbank_d;
    logic [AW-1:0]   widx_q, widx_d, ridx_q, ridx_d, s1_idx_q, s1_idx_d;
    logic            rd_done_q, rd_done_d, s1_vld_q, s1_vld_d;
    logic            drop_q, drop_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic            out_vld_q, out_vld_d, out_last_q, out_last_d;
    logic [15:0]     out_re_q, out_re_d;
    logic            sk0_last_q, sk0_last_d, sk1_last_q, sk1_last_d;
    logic [15:0]     sk0_re_q, sk0_re_d, sk1_re_q, sk1_re_d;
    logic [1:0]      sk_cnt_q, sk_cnt_d, sk_cnt_t;

    logic [7:0]      mem [2*FRAME_LEN];
    logic [7:0]      s1_dat_q;

    logic            wr_last, handoff, rd_issue, pop, in_last;
    logic [15:0]     in_re;
    logic [2:0]      occ;

`ifdef FFT_FEEDER_HANN_WINDOW_EN
    typedef logic [15:0] win_rom_t [FRAME_LEN];

    function automatic win_rom_t hann_rom();
        win_rom_t r;
        for (int i = 0; i < FRAME_LEN; i++) begin
            r[i] = 16'($rtoi(32767.5 * (1.0 - $cos(6.283185307179586 * i / FRAME_LEN)) + 0.5));
        end
        return r;
    endfunction

    localparam win_rom_t WIN_ROM = hann_rom();

    logic signed [23:0] prod;
    assign prod  = $signed(s1_dat_q) * $signed({1'b0, WIN_ROM[s1_idx_q]});
    assign in_re = prod[23:8];
`else
    assign in_re = {s1_dat_q, 8'h00};
`endif
    assign in_last = (s1_idx_q == LAST_IDX);

    // Read and write always target different banks, so one array serves both.
    always_ff @(posedge clk_in) begin
        if (sample_valid_in) begin
            mem[{wbank_q, widx_q}] <= sample_in;
        end
        if (rd_issue) begin
            s1_dat_q <= mem[{rbank_q, ridx_q}];
        end
    end

    always_comb begin
        wr_last    = sample_valid_in && (widx_q == LAST_IDX);
        handoff    = wr_last && (state_q == S_IDLE);
        widx_d     = sample_valid_in ? widx_q + 1'b1 : widx_q;
        wbank_d    = wbank_q ^ handoff;
        drop_d     = wr_last && (state_q != S_IDLE);
        drop_cnt_d = (drop_d && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    always_comb begin
        state_d   = state_q;
        rbank_d   = rbank_q;
        ridx_d    = ridx_q;
        rd_done_d = rd_done_q;
        rd_issue  = 1'b0;
        pop       = out_vld_q && m_axis_tready;
        occ       = {2'b00, s1_vld_q} + {2'b00, out_vld_q} + {1'b0, sk_cnt_q};
        case (state_q)
            S_IDLE: begin
                if (handoff) begin
                    state_d = S_FILL;
                    rbank_d = wbank_q;
                end
            end
            S_FILL: begin
                ridx_d    = '0;
                rd_done_d = 1'b0;
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                // A read is only issued when the output register plus skid can absorb it.
                rd_issue = !rd_done_q && (occ < (pop ? 3'd4 : 3'd3));
                if (rd_issue) begin
                    ridx_d = ridx_q + 1'b1;
                    if (ridx_q == LAST_IDX) begin
                        rd_done_d = 1'b1;
                    end
                end
                if (pop && out_last_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        s1_vld_d = rd_issue;
        s1_idx_d = rd_issue ? ridx_q : s1_idx_q;
    end

    always_comb begin
        out_vld_d  = out_vld_q;
        out_re_d   = out_re_q;
        out_last_d = out_last_q;
        sk0_re_d   = sk0_re_q;
        sk0_last_d = sk0_last_q;
        sk1_re_d   = sk1_re_q;
        sk1_last_d = sk1_last_q;
        sk_cnt_t   = sk_cnt_q;
        sk_cnt_d   = sk_cnt_q;
        if (out_vld_q && !pop) begin
            out_vld_d = 1'b1;
        end else if (sk_cnt_q != 2'd0) begin
            out_vld_d  = 1'b1;
            out_re_d   = sk0_re_q;
            out_last_d = sk0_last_q;
            sk0_re_d   = sk1_re_q;
            sk0_last_d = sk1_last_q;
            sk_cnt_t   = sk_cnt_q - 2'd1;
        end else begin
            out_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                out_re_d   = in_re;
                out_last_d = in_last;
            end
        end
        // Pipeline data that could not go straight to the output lands in the skid.
        sk_cnt_d = sk_cnt_t;
        if (s1_vld_q && ((out_vld_q && !pop) || sk_cnt_q != 2'd0)) begin
            if (sk_cnt_t == 2'd0) begin
                sk0_re_d   = in_re;
                sk0_last_d = in_last;
            end else begin
                sk1_re_d   = in_re;
                sk1_last_d = in_last;
            end
            sk_cnt_d = sk_cnt_t + 2'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            widx_q     <= '0;
            ridx_q     <= '0;
            s1_idx_q   <= '0;
            rd_done_q  <= 1'b0;
            s1_vld_q   <= 1'b0;
            drop_q     <= 1'b0;
            drop_cnt_q <= 8'd0;
            out_vld_q  <= 1'b0;
            out_re_q   <= 16'd0;
            out_last_q <= 1'b0;
            sk0_re_q   <= 16'd0;
            sk0_last_q <= 1'b0;
            sk1_re_q   <= 16'd0;
            sk1_last_q <= 1'b0;
            sk_cnt_q   <= 2'd0;
        end else begin
            state_q    <= state_d;
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            widx_q     <= widx_d;
            ridx_q     <= ridx_d;
            s1_idx_q   <= s1_idx_d;
            rd_done_q  <= rd_done_d;
            s1_vld_q   <= s1_vld_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
            out_vld_q  <= out_vld_d;
            out_re_q   <= out_re_d;
            out_last_q <= out_last_d;
            sk0_re_q   <= sk0_re_d;
            sk0_last_q <= sk0_last_d;
            sk1_re_q   <= sk1_re_d;
            sk1_last_q <= sk1_last_d;
            sk_cnt_q   <= sk_cnt_d;
        end
    end

    assign m_axis_tdata   = {16'h0000, out_re_q};
    assign m_axis_tvalid  = out_vld_q;
    assign m_axis_tlast   = out_last_q;
    assign frame_drop_out = drop_q;
    assign drop_count_out = drop_cnt_q;
endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder: frame-level reference model (sample capture, handoff/drop, beat queue) checked every cycle.
module tb_fft_frame_feeder;
    localparam int FRAME_LEN = 512;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [7:0]  sample_in = 8'd0;
    logic        sample_valid_in = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic        frame_drop_out;
    logic [7:0]  drop_count_out;

    int tests = 0;
    int fails = 0;

    fft_frame_feeder #(.FRAME_LEN(FRAME_LEN)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .frame_drop_out  (frame_drop_out),
        .drop_count_out  (drop_count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_re(input logic [7:0] s, input int n);
        int sv;
        int v;
        sv = int'($signed(s));
`ifdef FFT_FEEDER_HANN_WINDOW_EN
        v = sv * $rtoi(65535.0 * 0.5 * (1.0 - $cos(2.0 * 3.141592653589793 * n / FRAME_LEN)) + 0.5);
        v = v >>> 8;
`else
        v = sv * 256 + 0 * n;
`endif
        return v[15:0];
    endfunction

    typedef struct {
        logic [15:0] re;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [7:0]  frm[FRAME_LEN];
    logic [15:0] last_frame[FRAME_LEN];
    int          wcount = 0, beat_no = 0, tlast_cnt = 0, beats_total = 0, pulse_cnt = 0, exp_cnt = 0;
    bit          busy = 0, lat_pending = 0, exp_pulse = 0, prev_stall = 0;
    logic [31:0] prev_dat = 32'd0;
    logic        prev_last = 1'b0;
    int unsigned cyc = 0, hand_cyc = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            exp_q.delete();
            wcount = 0; beat_no = 0; busy = 0; lat_pending = 0;
            exp_pulse = 0; prev_stall = 0; exp_cnt = 0;
        end else begin
            bit accept, nxt_pulse;
            chk("drop_pulse", 32'(frame_drop_out), 32'(exp_pulse));
            chk("drop_count", 32'(drop_count_out), 32'(exp_cnt));
            if (frame_drop_out) pulse_cnt++;
            if (!busy) chk("idle_tvalid", 32'(m_axis_tvalid), 32'd0);
            if (prev_stall) begin
                chk("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
                chk("stall_tdata", m_axis_tdata, prev_dat);
                chk("stall_tlast", 32'(m_axis_tlast), 32'(prev_last));
            end
            if (lat_pending && m_axis_tvalid) begin
                chk("latency", cyc - hand_cyc, 32'd3);
                lat_pending = 0;
            end
            accept = m_axis_tvalid && m_axis_tready;
            if (accept) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_tdata", m_axis_tdata, {16'h0000, e.re});
                    chk("beat_tlast", 32'(m_axis_tlast), 32'(e.last));
                end
                if (beat_no < FRAME_LEN) last_frame[beat_no] = m_axis_tdata[15:0];
                beat_no++;
                beats_total++;
                if (m_axis_tlast) begin
                    tlast_cnt++;
                    beat_no = 0;
                end
            end
            nxt_pulse = 0;
            if (sample_valid_in) begin
                frm[wcount] = sample_in;
                wcount++;
                if (wcount == FRAME_LEN) begin
                    wcount = 0;
                    if (busy) begin
                        nxt_pulse = 1;
                        if (exp_cnt < 255) exp_cnt++;
                    end else begin
                        for (int i = 0; i < FRAME_LEN; i++)
                            exp_q.push_back('{re: exp_re(frm[i], i), last: (i == FRAME_LEN - 1)});
                        hand_cyc = cyc + 1;
                        lat_pending = 1;
                    end
                end
            end
            if (accept && m_axis_tlast) busy = 0;
            if (lat_pending && !busy && exp_q.size() != 0) busy = 1;
            exp_pulse = nxt_pulse;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_dat = m_axis_tdata;
            prev_last = m_axis_tlast;
        end
    end

    int         rdy_mode = 0;
    int         smp_mode = 0;
    int         sidx = 0;
    logic [7:0] sconst = 8'd0;

    task automatic step();
        @(posedge clk_in);
        #1;
        case (rdy_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = ~m_axis_tready;
            2: m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
        endcase
    endtask

    task automatic feed(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            case (smp_mode)
                0: sample_in = 8'(sidx);
                1: sample_in = sconst;
                default: sample_in = 8'($urandom);
            endcase
            sample_valid_in = 1'b1;
            step();
            sample_valid_in = 1'b0;
            for (int g = 1; g < gap; g++) step();
            sidx++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < budget) begin
            step();
            k++;
        end
        chk("idle_timeout", 32'(busy || exp_q.size() != 0), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, t0;
        step(); step(); step();
        chk("rst_tdata", m_axis_tdata, 32'd0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_drop", 32'(frame_drop_out), 32'd0);
        chk("rst_count", 32'(drop_count_out), 32'd0);
        rst_n_in = 1'b1;
        step();

        // Ramp frame, one sample every 4 cycles.
        rdy_mode = 0; smp_mode = 0; sidx = 0; tlast_cnt = 0; beats_total = 0;
        feed(FRAME_LEN, 4);
        wait_idle(2000);
        chk("ramp_beats", 32'(beats_total), 32'(FRAME_LEN));
        chk("ramp_tlasts", 32'(tlast_cnt), 32'd1);
`ifdef FFT_FEEDER_HANN_WINDOW_EN
        smp_mode = 1; sconst = 8'h7F;
        feed(FRAME_LEN, 2);
        wait_idle(2000);
        chk("hann_b0", 32'(last_frame[0]), 32'd0);
        chk("hann_b256_pos", 32'(last_frame[256]), 32'd32511);
        sconst = 8'h80;
        feed(FRAME_LEN, 2);
        wait_idle(2000);
        chk("hann_b256_neg", 32'(last_frame[256]), 32'h8000);
`else
        chk("rect_b0", 32'(last_frame[0]), 32'h0000);
        chk("rect_b1", 32'(last_frame[1]), 32'h0100);
        chk("rect_b255", 32'(last_frame[255]), 32'hFF00);
        chk("rect_b511", 32'(last_frame[511]), 32'hFF00);
`endif

        // Backpressure: toggling, then random tready.
        rdy_mode = 1; smp_mode = 0;
        feed(2 * FRAME_LEN, 3);
        wait_idle(4000);
        rdy_mode = 2; smp_mode = 2;
        feed(2 * FRAME_LEN, 4);
        wait_idle(4000);
        rdy_mode = 0;
        chk("bp_no_drop", 32'(drop_count_out), 32'd0);

        // Drop: second frame arrives while the first is stalled.
        p0 = pulse_cnt;
        rdy_mode = 3; m_axis_tready = 1'b0; smp_mode = 0; sidx = 0;
        feed(2 * FRAME_LEN, 2);
        step();
        chk("drop_count_one", 32'(drop_count_out), 32'd1);
        chk("drop_pulses", 32'(pulse_cnt - p0), 32'd1);
        rdy_mode = 0;
        feed(FRAME_LEN, 2);
        wait_idle(3000);

        // Reset at beat 100 of a streaming frame.
        smp_mode = 2;
        feed(FRAME_LEN, 1);
        begin
            int k = 0;
            while (beat_no < 100 && k < 2000) begin
                step();
                k++;
            end
            chk("beat100_timeout", 32'(beat_no >= 100), 32'd1);
        end
        rst_n_in = 1'b0;
        #1;
        chk("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_mid_count", 32'(drop_count_out), 32'd0);
        step(); step();
        rst_n_in = 1'b1;
        feed(FRAME_LEN, 2);
        wait_idle(2000);

        // Back-to-back frames.
        t0 = tlast_cnt;
        feed(4 * FRAME_LEN, 2);
        wait_idle(2000);
        chk("b2b_frames", 32'(tlast_cnt - t0), 32'd4);
        chk("b2b_no_drop", 32'(drop_count_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
